// File: rtl/evm_pkg.sv
// evm_pkg: shared widths, FSM state encodings and button helpers for the EVM ballot controller.
// The optional debounce stage in evm_button_sync is enabled by defining EVM_DEBOUNCE_EN.
package evm_pkg;

    localparam int NUM_PARTIES = 4;
    localparam int PARTY_W     = 2;
    localparam int VOTE_CNT_W  = 7;
    localparam int OFFICER_W   = 4;

    localparam logic [2:0] ST_PRE     = 3'd0;
    localparam logic [2:0] ST_OPEN    = 3'd1;
    localparam logic [2:0] ST_ARMED   = 3'd2;
    localparam logic [2:0] ST_CAST    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_RESULT  = 3'd5;

    // Bit positions of the officer inputs inside the shared synchronizer vector.
    typedef enum int {
        OFF_OPEN  = 0,
        OFF_ISSUE = 1,
        OFF_CLOSE = 2,
        OFF_CLEAR = 3
    } officer_bit_e;

    function automatic logic [PARTY_W-1:0] onehot_to_idx(input logic [NUM_PARTIES-1:0] oh);
        logic [PARTY_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PARTIES; i++) begin
            if (oh[i]) idx = PARTY_W'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [NUM_PARTIES-1:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic logic is_multi(input logic [NUM_PARTIES-1:0] v);
        return $countones(v) > 1;
    endfunction

endpackage

// File: rtl/evm_button_sync.sv
// evm_button_sync: per-bit two-flop synchronizer for asynchronous front-panel inputs.
// With EVM_DEBOUNCE_EN defined, an output only follows the input after DEBOUNCE_CYCLES stable samples.
module evm_button_sync #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("evm_button_sync: DEBOUNCE_CYCLES must be at least 1");
    end

`ifdef EVM_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [WIDTH-1:0] stable_q;

    // Down-counter per bit restarts whenever the sample agrees with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= CNT_LOAD;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_q[i] == stable_q[i]) begin
                    cnt_q[i] <= CNT_LOAD;
                end else if (cnt_q[i] == '0) begin
                    stable_q[i] <= sync_q[i];
                    cnt_q[i]    <= CNT_LOAD;
                end else begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    assign sync_o = stable_q;
`else
    assign sync_o = sync_q;
`endif

endmodule

// File: rtl/evm_ballot_controller.sv
// evm_ballot_controller: presiding-officer/voter sequencer driving the EVM vote counter.
// Optional button debounce is selected with the EVM_DEBOUNCE_EN macro (see evm_button_sync).
//
//   state   | meaning
//   PRE     | poll not yet opened; counts may be cleared
//   OPEN    | waiting for the officer to issue a ballot or close the poll
//   ARMED   | ballot issued, voter lamp on, waiting for exactly one button
//   CAST    | one-cycle count enable to the counter
//   RELEASE | waiting for every button to be released
//   RESULT  | poll closed, counter shows the result
module evm_ballot_controller
    import evm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int MAX_VOTERS      = 127,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   open_poll,
    input  logic                   ballot_issue,
    input  logic                   close_poll,
    input  logic                   clear_req,
    input  logic [NUM_PARTIES-1:0] party_btn,
    output logic                   mode,
    output logic                   control,
    output logic [PARTY_W-1:0]     incr_party_vote,
    output logic                   show_result,
    output logic                   system_reset,
    output logic                   ballot_ready,
    output logic [VOTE_CNT_W-1:0]  voters_served,
    output logic                   poll_full,
    output logic                   timeout_err,
    output logic                   multi_press_err
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]      TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [VOTE_CNT_W-1:0] MAX_V    = VOTE_CNT_W'(MAX_VOTERS);

    logic [NUM_PARTIES-1:0] btn_s;
    logic [OFFICER_W-1:0]   off_s;
    logic [OFFICER_W-1:0]   off_q;
    logic [OFFICER_W-1:0]   off_rise;

    logic [2:0]            state_q,  state_d;
    logic [TMR_W-1:0]      timer_q,  timer_d;
    logic [PARTY_W-1:0]    idx_q,    idx_d;
    logic [VOTE_CNT_W-1:0] served_q, served_d;
    logic                  tmo_q,    tmo_d;
    logic                  multi_q,  multi_d;
    logic                  sysrst_q, sysrst_d;
    logic                  rdy_q,    rdy_d;

    evm_button_sync #(
        .WIDTH          (NUM_PARTIES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_sync (
        .clk    (clk),
        .rst_n  (reset),
        .async_i(party_btn),
        .sync_o (btn_s)
    );

    evm_button_sync #(
        .WIDTH          (OFFICER_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_off_sync (
        .clk    (clk),
        .rst_n  (reset),
        .async_i({clear_req, close_poll, ballot_issue, open_poll}),
        .sync_o (off_s)
    );

    assign off_rise = off_s & ~off_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        served_d = served_q;
        tmo_d    = tmo_q;
        multi_d  = multi_q;
        sysrst_d = 1'b0;
        rdy_d    = rdy_q;
        case (state_q)
            ST_PRE: begin
                if (off_rise[OFF_CLEAR]) begin
                    sysrst_d = 1'b1;
                    served_d = '0;
                end else if (off_rise[OFF_OPEN]) begin
                    state_d = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (off_rise[OFF_CLOSE]) begin
                    state_d = ST_RESULT;
                end else if (off_rise[OFF_ISSUE] && !poll_full) begin
                    state_d = ST_ARMED;
                    timer_d = TMR_LOAD;
                    tmo_d   = 1'b0;
                    multi_d = 1'b0;
                    // A button already held at issue time must be released before it can vote.
                    rdy_d   = (btn_s == '0);
                end
            end
            ST_ARMED: begin
                if (is_multi(btn_s)) multi_d = 1'b1;
                if (btn_s == '0) begin
                    rdy_d = 1'b1;
                end else if (is_multi(btn_s)) begin
                    rdy_d = 1'b0;
                end
                if (rdy_q && is_onehot(btn_s)) begin
                    state_d = ST_CAST;
                    idx_d   = onehot_to_idx(btn_s);
                end else if (timer_q == '0) begin
                    state_d = ST_OPEN;
                    tmo_d   = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_CAST: begin
                if (served_q != MAX_V) served_d = served_q + VOTE_CNT_W'(1);
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (btn_s == '0) state_d = ST_OPEN;
            end
            ST_RESULT: begin
                if (off_rise[OFF_CLEAR]) begin
                    sysrst_d = 1'b1;
                    served_d = '0;
                    state_d  = ST_PRE;
                end
            end
            default: state_d = ST_PRE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_PRE;
            timer_q  <= '0;
            idx_q    <= '0;
            served_q <= '0;
            tmo_q    <= 1'b0;
            multi_q  <= 1'b0;
            sysrst_q <= 1'b0;
            rdy_q    <= 1'b0;
            off_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            served_q <= served_d;
            tmo_q    <= tmo_d;
            multi_q  <= multi_d;
            sysrst_q <= sysrst_d;
            rdy_q    <= rdy_d;
            off_q    <= off_s;
        end
    end

    assign mode            = (state_q != ST_RESULT);
    assign control         = (state_q == ST_CAST);
    assign incr_party_vote = control ? idx_q : '0;
    assign show_result     = (state_q == ST_RESULT);
    assign system_reset    = sysrst_q;
    assign ballot_ready    = (state_q == ST_ARMED);
    assign voters_served   = served_q;
    assign poll_full       = (served_q == MAX_V);
    assign timeout_err     = tmo_q;
    assign multi_press_err = multi_q;

endmodule

// File: tb/tb_evm_ballot_controller.sv
// Self-checking bench for evm_ballot_controller: vote scoreboard plus table-driven ballots.
module tb_evm_ballot_controller;

    localparam int TMO  = 40;
    localparam int MAXV = 3;
    localparam int OPEN_B  = 0;
    localparam int ISSUE_B = 1;
    localparam int CLOSE_B = 2;
    localparam int CLEAR_B = 3;
    localparam logic [16:0] RST_OUTS = {1'b1, 16'b0};

    typedef struct packed {
        logic [3:0] btn;
        logic [1:0] party;
        logic [6:0] served;
        logic       full;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] off_drv;
    logic [3:0] btn;
    logic       mode, control, show_result, system_reset, ballot_ready;
    logic [1:0] incr_party_vote;
    logic [6:0] voters_served;
    logic       poll_full, timeout_err, multi_press_err;

    int         total = 0;
    int         passed = 0;
    logic [1:0] exp_q [$];
    logic [1:0] mon_exp;
    vec_t       vecs [3];

    always #5 clk = ~clk;

    evm_ballot_controller #(
        .TIMEOUT_CYCLES (TMO),
        .MAX_VOTERS     (MAXV),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .open_poll      (off_drv[OPEN_B]),
        .ballot_issue   (off_drv[ISSUE_B]),
        .close_poll     (off_drv[CLOSE_B]),
        .clear_req      (off_drv[CLEAR_B]),
        .party_btn      (btn),
        .mode           (mode),
        .control        (control),
        .incr_party_vote(incr_party_vote),
        .show_result    (show_result),
        .system_reset   (system_reset),
        .ballot_ready   (ballot_ready),
        .voters_served  (voters_served),
        .poll_full      (poll_full),
        .timeout_err    (timeout_err),
        .multi_press_err(multi_press_err)
    );

    function automatic logic [16:0] outs();
        return {mode, control, incr_party_vote, show_result, system_reset, ballot_ready,
                voters_served, poll_full, timeout_err, multi_press_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int idx);
        off_drv[idx] = 1'b1;
        tick(4);
        off_drv[idx] = 1'b0;
        tick(3);
    endtask

    task automatic press_release(input logic [3:0] b, input logic [1:0] party);
        exp_q.push_back(party);
        btn = b;
        tick(5);
        btn = '0;
        tick(4);
    endtask

    // Every count enable must match the oldest outstanding expected vote.
    always @(negedge clk) begin
        if (reset && control) begin
            if (exp_q.size() == 0) begin
                check("unexpected_control", 32'(control), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("vote_party", 32'(incr_party_vote), 32'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{btn: 4'b0001, party: 2'd0, served: 7'd1, full: 1'b0};
        vecs[1] = '{btn: 4'b1000, party: 2'd3, served: 7'd2, full: 1'b0};
        vecs[2] = '{btn: 4'b0010, party: 2'd1, served: 7'd3, full: 1'b1};

        reset   = 1'b1;
        off_drv = '0;
        btn     = '0;
        #2 reset = 1'b0;
        tick(3);
        check("reset_outputs", 32'(outs()), 32'(RST_OUTS));
        reset = 1'b1;
        tick(2);

        // Clear in PRE: single-cycle system_reset, stays in PRE (mode stays 1).
        off_drv[CLEAR_B] = 1'b1;
        tick(3);
        check("pre_clear_pulse", 32'(system_reset), 32'd1);
        tick(1);
        check("pre_clear_width", 32'(system_reset), 32'd0);
        off_drv[CLEAR_B] = 1'b0;
        tick(3);
        pulse(ISSUE_B);
        check("pre_issue_ignored", 32'(ballot_ready), 32'd0);

        pulse(OPEN_B);
        pulse(ISSUE_B);
        check("armed_ready", 32'(ballot_ready), 32'd1);
        press_release(4'b0100, 2'd2);
        check("vote1_served", 32'(voters_served), 32'd1);
        check("vote1_back_open", 32'(ballot_ready), 32'd0);

        // Two buttons at once: error, no vote, retry after release.
        pulse(ISSUE_B);
        btn = 4'b0011;
        tick(5);
        check("multi_err", 32'(multi_press_err), 32'd1);
        check("multi_still_armed", 32'(ballot_ready), 32'd1);
        btn = '0;
        tick(4);
        press_release(4'b1000, 2'd3);
        check("vote2_served", 32'(voters_served), 32'd2);
        check("multi_err_sticky", 32'(multi_press_err), 32'd1);

        // Idle ballot: still armed on the last timer cycle, voided on the next.
        pulse(ISSUE_B);
        check("issue_clears_multi", 32'(multi_press_err), 32'd0);
        tick(TMO - 5);
        check("tmo_last_armed", 32'(ballot_ready), 32'd1);
        check("tmo_not_yet", 32'(timeout_err), 32'd0);
        tick(1);
        check("tmo_back_open", 32'(ballot_ready), 32'd0);
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_served", 32'(voters_served), 32'd2);

        // Button held before and through the issue: no vote until release and re-press.
        btn = 4'b0010;
        tick(4);
        pulse(ISSUE_B);
        check("held_armed", 32'(ballot_ready), 32'd1);
        check("issue_clears_tmo", 32'(timeout_err), 32'd0);
        tick(6);
        check("held_no_vote", 32'(voters_served), 32'd2);
        btn = '0;
        tick(4);
        press_release(4'b0010, 2'd1);
        check("vote3_served", 32'(voters_served), 32'd3);
        check("poll_full", 32'(poll_full), 32'd1);

        pulse(ISSUE_B);
        check("full_issue_ignored", 32'(ballot_ready), 32'd0);
        pulse(CLOSE_B);
        check("result_mode", 32'(mode), 32'd0);
        check("result_show", 32'(show_result), 32'd1);

        off_drv[CLEAR_B] = 1'b1;
        tick(3);
        check("result_clear_pulse", 32'(system_reset), 32'd1);
        check("clear_to_pre_mode", 32'(mode), 32'd1);
        check("clear_show_off", 32'(show_result), 32'd0);
        check("clear_served", 32'(voters_served), 32'd0);
        tick(1);
        check("result_clear_width", 32'(system_reset), 32'd0);
        off_drv[CLEAR_B] = 1'b0;
        tick(3);

        // Reset asserted while the count enable is high: vote lost, reset values at once.
        pulse(OPEN_B);
        pulse(ISSUE_B);
        btn = 4'b0100;
        tick(3);
        check("cast_control", 32'(control), 32'd1);
        check("cast_party", 32'(incr_party_vote), 32'd2);
        reset = 1'b0;
        #1;
        check("cast_reset_now", 32'(outs()), 32'(RST_OUTS));
        tick(1);
        check("cast_reset_next", 32'(outs()), 32'(RST_OUTS));
        btn = '0;
        tick(2);
        reset = 1'b1;
        tick(3);

        pulse(OPEN_B);
        for (int i = 0; i < 3; i++) begin
            pulse(ISSUE_B);
            check($sformatf("vec%0d_ready", i), 32'(ballot_ready), 32'd1);
            press_release(vecs[i].btn, vecs[i].party);
            check($sformatf("vec%0d_served", i), 32'(voters_served), 32'(vecs[i].served));
            check($sformatf("vec%0d_full", i), 32'(poll_full), 32'(vecs[i].full));
        end

        tick(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
